control_sequencer: RTL and testbench

Hardwired control unit for the 32-bit bus datapath (`main1`). It sits directly upstream of the datapath and consumes the datapath's IR value. It steps through fetch (T0–T2) and execute (T3–T6) states, and drives every register-enable, bus-select, memory-read and ALU-select strobe for the arithmetic and logical instruction group. It replaces hand-sequenced control stimulus: each strobe is a pure function of the current state and the IR contents.

---
 rtl/control_sequencer.sv | 169 ++++++++++++++++
 tb/tb_control_sequencer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute control unit for the 32-bit bus datapath.
// Strobes decode from the state register and IR only. 'illegal' is the only other register.
module control_sequencer #(
  parameter int NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [31:0]         IR,
  output logic [NUM_REGS-1:0] Rin,
  output logic [NUM_REGS-1:0] Rout,
  output logic                PCout,
  output logic                PCin,
  output logic                IncPC,
  output logic                MARin,
  output logic                MDRin,
  output logic                MDRout,
  output logic                Read,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                ZLowout,
  output logic                ZHighout,
  output logic                HIin,
  output logic                LOin,
  output logic [3:0]          ALUselect,
  output logic                instr_done,
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  state_t      state, next_state;
  logic        set_illegal;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic        is_three, is_muldiv, is_unary;
  logic [3:0]  alu_code;
  logic        unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    onehot = NUM_REGS'(1) << idx;
  endfunction

  always_comb begin
    is_three  = 1'b0;
    is_muldiv = 1'b0;
    is_unary  = 1'b0;
    alu_code  = 4'b0000;
    case (opcode)
      5'b00011: begin is_three  = 1'b1; alu_code = 4'b0001; end
      5'b00100: begin is_three  = 1'b1; alu_code = 4'b0010; end
      5'b00101: begin is_three  = 1'b1; alu_code = 4'b0101; end
      5'b00110: begin is_three  = 1'b1; alu_code = 4'b1000; end
      5'b00111: begin is_three  = 1'b1; alu_code = 4'b1001; end
      5'b01000: begin is_three  = 1'b1; alu_code = 4'b1010; end
      5'b01001: begin is_three  = 1'b1; alu_code = 4'b0110; end
      5'b01010: begin is_three  = 1'b1; alu_code = 4'b0111; end
      5'b01110: begin is_muldiv = 1'b1; alu_code = 4'b0011; end
      5'b01111: begin is_muldiv = 1'b1; alu_code = 4'b0100; end
      5'b10000: begin is_unary  = 1'b1; alu_code = 4'b1011; end
      5'b10001: begin is_unary  = 1'b1; alu_code = 4'b1100; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (set_illegal) illegal <= 1'b1;
    end
  end

  always_comb begin
    next_state  = state;
    set_illegal = 1'b0;
    Rin         = '0;
    Rout        = '0;
    PCout       = 1'b0;
    PCin        = 1'b0;
    IncPC       = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    Read        = 1'b0;
    IRin        = 1'b0;
    Yin         = 1'b0;
    Zin         = 1'b0;
    ZLowout     = 1'b0;
    ZHighout    = 1'b0;
    HIin        = 1'b0;
    LOin        = 1'b0;
    ALUselect   = 4'b0000;
    instr_done  = 1'b0;
    case (state)
      S_IDLE: if (run) next_state = S_T0;
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        next_state = S_T2;
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T4;
        if (is_three) begin
          Rout = onehot(rb); Yin = 1'b1;
        end else if (is_muldiv) begin
          Rout = onehot(ra); Yin = 1'b1;
        end else if (is_unary) begin
          Rout = onehot(rb); ALUselect = alu_code; Zin = 1'b1;
        end else begin
          next_state  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      // Unary ops retire here; the other classes still need the Z result.
      S_T4: begin
        next_state = S_T5;
        if (is_three) begin
          Rout = onehot(rc); ALUselect = alu_code; Zin = 1'b1;
        end else if (is_muldiv) begin
          Rout = onehot(rb); ALUselect = alu_code; Zin = 1'b1;
        end else if (is_unary) begin
          ZLowout = 1'b1; Rin = onehot(ra); instr_done = 1'b1;
          next_state = run ? S_T0 : S_IDLE;
        end else begin
          next_state  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_T5: begin
        if (is_three) begin
          ZLowout = 1'b1; Rin = onehot(ra); instr_done = 1'b1;
          next_state = run ? S_T0 : S_IDLE;
        end else if (is_muldiv) begin
          ZLowout = 1'b1; LOin = 1'b1;
          next_state = S_T6;
        end else begin
          next_state  = S_HALT;
          set_illegal = 1'b1;
        end
      end
      S_T6: begin
        ZHighout = 1'b1; HIin = 1'b1; instr_done = 1'b1;
        next_state = run ? S_T0 : S_IDLE;
      end
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: a cycle-by-cycle vector table plus
// hand-written reset-mid-instruction and illegal-opcode sequences.
module tb_control_sequencer;

  localparam logic [13:0] PCOUT  = 14'h2000;
  localparam logic [13:0] PCIN   = 14'h1000;
  localparam logic [13:0] INCPC  = 14'h0800;
  localparam logic [13:0] MARIN  = 14'h0400;
  localparam logic [13:0] MDRIN  = 14'h0200;
  localparam logic [13:0] MDROUT = 14'h0100;
  localparam logic [13:0] READ   = 14'h0080;
  localparam logic [13:0] IRIN   = 14'h0040;
  localparam logic [13:0] YIN    = 14'h0020;
  localparam logic [13:0] ZIN    = 14'h0010;
  localparam logic [13:0] ZLO    = 14'h0008;
  localparam logic [13:0] ZHI    = 14'h0004;
  localparam logic [13:0] HIIN   = 14'h0002;
  localparam logic [13:0] LOIN   = 14'h0001;
  localparam logic [13:0] F_T0   = PCOUT | MARIN | INCPC | ZIN;
  localparam logic [13:0] F_T1   = ZLO | PCIN | READ | MDRIN;
  localparam logic [13:0] F_T2   = MDROUT | IRIN;

  localparam logic [31:0] IR_AND = 32'h4A920000;
  localparam logic [31:0] IR_MUL = 32'h71200000;
  localparam logic [31:0] IR_NEG = 32'h81200000;
  localparam logic [31:0] IR_BAD = 32'hF8000000;
  localparam logic [31:0] IR_SUB = {5'b00100, 4'd1, 4'd3, 4'd7, 15'd0};
  localparam logic [31:0] IR_ADD = {5'b00011, 4'd6, 4'd7, 4'd8, 15'd0};

  typedef struct packed {
    logic        rstn;
    logic        run;
    logic [31:0] ir;
    logic [51:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin;
  logic        Yin, Zin, ZLowout, ZHighout, HIin, LOin;
  logic [3:0]  ALUselect;
  logic        instr_done, illegal;
  logic [13:0] strb;
  logic [51:0] obs;
  int          checks;
  int          errors;
  vec_t        vecs[$];

  control_sequencer #(.NUM_REGS(16)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .IR(IR),
    .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .MDRin(MDRin), .MDRout(MDRout), .Read(Read), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .ZLowout(ZLowout), .ZHighout(ZHighout),
    .HIin(HIin), .LOin(LOin), .ALUselect(ALUselect),
    .instr_done(instr_done), .illegal(illegal)
  );

  assign strb = {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, IRin,
                 Yin, Zin, ZLowout, ZHighout, HIin, LOin};
  assign obs  = {Rin, Rout, strb, ALUselect, instr_done, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [51:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                     input logic [13:0] s, input logic [3:0] alu,
                                     input logic done, input logic ill);
    mk = {rin, rout, s, alu, done, ill};
  endfunction

  task automatic applyStimulus(input logic rstn, input logic r, input logic [31:0] ir);
    rst_n = rstn;
    run   = r;
    IR    = ir;
  endtask

  task automatic checkOutput(input string name, input logic [51:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic step(input string name, input logic rstn, input logic r,
                      input logic [31:0] ir, input logic [51:0] exp);
    applyStimulus(rstn, r, ir);
    @(negedge clk);
    checkOutput(name, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic r, input logic [31:0] ir, input logic [51:0] exp);
    vecs.push_back('{rstn: 1'b1, run: r, ir: ir, exp: exp});
  endtask

  initial begin
    logic [51:0] zero;
    checks = 0;
    errors = 0;
    zero   = '0;

    // Continuous cycle stream from IDLE: and, mul, neg, sub, then add with run dropped.
    add_vec(1, IR_AND, zero);
    add_vec(1, IR_AND, mk(0, 0, F_T0, 0, 0, 0));
    add_vec(1, IR_AND, mk(0, 0, F_T1, 0, 0, 0));
    add_vec(1, IR_AND, mk(0, 0, F_T2, 0, 0, 0));
    add_vec(1, IR_AND, mk(0, 16'h0004, YIN, 0, 0, 0));
    add_vec(1, IR_AND, mk(0, 16'h0010, ZIN, 4'b0110, 0, 0));
    add_vec(1, IR_AND, mk(16'h0020, 0, ZLO, 0, 1, 0));
    add_vec(1, IR_MUL, mk(0, 0, F_T0, 0, 0, 0));
    add_vec(1, IR_MUL, mk(0, 0, F_T1, 0, 0, 0));
    add_vec(1, IR_MUL, mk(0, 0, F_T2, 0, 0, 0));
    add_vec(1, IR_MUL, mk(0, 16'h0004, YIN, 0, 0, 0));
    add_vec(1, IR_MUL, mk(0, 16'h0010, ZIN, 4'b0011, 0, 0));
    add_vec(1, IR_MUL, mk(0, 0, ZLO | LOIN, 0, 0, 0));
    add_vec(1, IR_MUL, mk(0, 0, ZHI | HIIN, 0, 1, 0));
    add_vec(1, IR_NEG, mk(0, 0, F_T0, 0, 0, 0));
    add_vec(1, IR_NEG, mk(0, 0, F_T1, 0, 0, 0));
    add_vec(1, IR_NEG, mk(0, 0, F_T2, 0, 0, 0));
    add_vec(1, IR_NEG, mk(0, 16'h0010, ZIN, 4'b1011, 0, 0));
    add_vec(0, IR_NEG, mk(16'h0004, 0, ZLO, 0, 1, 0));
    add_vec(0, IR_SUB, zero);
    add_vec(1, IR_SUB, zero);
    add_vec(1, IR_SUB, mk(0, 0, F_T0, 0, 0, 0));
    add_vec(1, IR_SUB, mk(0, 0, F_T1, 0, 0, 0));
    add_vec(1, IR_SUB, mk(0, 0, F_T2, 0, 0, 0));
    add_vec(1, IR_SUB, mk(0, 16'h0008, YIN, 0, 0, 0));
    add_vec(1, IR_SUB, mk(0, 16'h0080, ZIN, 4'b0010, 0, 0));
    add_vec(1, IR_SUB, mk(16'h0002, 0, ZLO, 0, 1, 0));
    add_vec(1, IR_ADD, mk(0, 0, F_T0, 0, 0, 0));
    add_vec(1, IR_ADD, mk(0, 0, F_T1, 0, 0, 0));
    add_vec(1, IR_ADD, mk(0, 0, F_T2, 0, 0, 0));
    add_vec(1, IR_ADD, mk(0, 16'h0080, YIN, 0, 0, 0));
    add_vec(0, IR_ADD, mk(0, 16'h0100, ZIN, 4'b0001, 0, 0));
    add_vec(0, IR_ADD, mk(16'h0040, 0, ZLO, 0, 1, 0));
    add_vec(0, IR_ADD, zero);
    add_vec(0, IR_ADD, zero);

    applyStimulus(0, 1, 32'h0);
    @(posedge clk);
    #1;
    step("reset_cycle1", 0, 1, 32'h0, zero);
    step("reset_cycle2", 0, 1, 32'h0, zero);

    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].run, vecs[i].ir, vecs[i].exp);

    // Reset lands during T4 of a mul: the LOin/HIin states must never appear.
    step("mulrst_idle", 1, 1, IR_MUL, zero);
    step("mulrst_t0",   1, 1, IR_MUL, mk(0, 0, F_T0, 0, 0, 0));
    step("mulrst_t1",   1, 1, IR_MUL, mk(0, 0, F_T1, 0, 0, 0));
    step("mulrst_t2",   1, 1, IR_MUL, mk(0, 0, F_T2, 0, 0, 0));
    step("mulrst_t3",   1, 1, IR_MUL, mk(0, 16'h0004, YIN, 0, 0, 0));
    step("mulrst_t4",   0, 0, IR_MUL, mk(0, 16'h0010, ZIN, 4'b0011, 0, 0));
    step("mulrst_held", 0, 1, IR_MUL, zero);
    for (int k = 0; k < 3; k++)
      step($sformatf("mulrst_idle_after%0d", k), 1, 0, IR_MUL, zero);

    // Unsupported opcode: HALT with sticky illegal until reset.
    step("bad_idle", 1, 1, IR_BAD, zero);
    step("bad_t0",   1, 1, IR_BAD, mk(0, 0, F_T0, 0, 0, 0));
    step("bad_t1",   1, 1, IR_BAD, mk(0, 0, F_T1, 0, 0, 0));
    step("bad_t2",   1, 1, IR_BAD, mk(0, 0, F_T2, 0, 0, 0));
    step("bad_t3",   1, 1, IR_BAD, zero);
    for (int k = 0; k < 3; k++)
      step($sformatf("halt%0d", k), 1, k[0], IR_ADD, mk(0, 0, 0, 0, 0, 1));
    step("halt_rst_edge", 0, 1, IR_ADD, mk(0, 0, 0, 0, 0, 1));
    step("halt_cleared",  1, 1, IR_ADD, zero);
    step("restart_t0",    1, 0, IR_ADD, mk(0, 0, F_T0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
